// File: rtl/vend_txn_controller.sv
// Transaction controller for a 4-product vending machine: credit, selection, motor dispense, greedy change.
// Define VEND_STOCK_EN to add per-product stock counters and the sold_out pulse.
module vend_txn_controller #(
    parameter int CREDIT_W     = 8,
    parameter int MAX_CREDIT   = 200,
    parameter int PRICE0       = 25,
    parameter int PRICE1       = 35,
    parameter int PRICE2       = 50,
    parameter int PRICE3       = 65,
    parameter int DISP_TIMEOUT = 16,
    parameter int STOCK_INIT   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                motor_req,
    output logic [1:0]          motor_id,
    input  logic                motor_ack,
    output logic                change_valid,
    output logic [1:0]          change_type,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                insufficient,
    output logic                sold_out,
    output logic                fault,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int TW = $clog2(DISP_TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [1:0]          sel_q, sel_nxt;
    logic [TW-1:0]       tcnt, tcnt_nxt;
    logic                coin_reject_nxt, insufficient_nxt, sold_out_nxt, fault_nxt;
    logic [CREDIT_W-1:0] coin_val, sel_price, vend_price, change_val;
    logic [1:0]          change_sel;
    logic                coin_ok, coin_fits;
    logic [CREDIT_W:0]   coin_sum;
    logic                stock_empty, stock_dec;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        case (id)
            2'd0:    price_of = CREDIT_W'(PRICE0);
            2'd1:    price_of = CREDIT_W'(PRICE1);
            2'd2:    price_of = CREDIT_W'(PRICE2);
            default: price_of = CREDIT_W'(PRICE3);
        endcase
    endfunction

    assign sel_price  = price_of(sel_id);
    assign vend_price = price_of(sel_q);

    always_comb begin
        coin_val = '0;
        coin_ok  = 1'b1;
        case (coin_type)
            2'b00:   coin_val = CREDIT_W'(5);
            2'b01:   coin_val = CREDIT_W'(10);
            2'b10:   coin_val = CREDIT_W'(25);
            default: coin_ok  = 1'b0;
        endcase
    end

    // One extra bit so a coin on top of high credit cannot wrap past the limit check.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = coin_ok && (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT));

    always_comb begin
        if (credit_q >= CREDIT_W'(25)) begin
            change_sel = 2'b10;
            change_val = CREDIT_W'(25);
        end else if (credit_q >= CREDIT_W'(10)) begin
            change_sel = 2'b01;
            change_val = CREDIT_W'(10);
        end else begin
            change_sel = 2'b00;
            change_val = CREDIT_W'(5);
        end
    end

    // Handshakes: motor_req / change_valid stay high, with motor_id / change_type stable,
    // until the matching ack is sampled high on a rising edge; the request drops or moves on next cycle.
    assign motor_req    = (state == VEND);
    assign motor_id     = sel_q;
    assign change_valid = (state == CHANGE) && (credit_q != '0);
    assign change_type  = change_valid ? change_sel : 2'b00;
    assign credit       = credit_q;
    assign busy         = (state == VEND) || (state == CHANGE);
    assign state_dbg    = state;

    always_comb begin
        state_nxt        = state;
        credit_nxt       = credit_q;
        sel_nxt          = sel_q;
        tcnt_nxt         = '0;
        coin_reject_nxt  = 1'b0;
        insufficient_nxt = 1'b0;
        sold_out_nxt     = 1'b0;
        fault_nxt        = 1'b0;
        stock_dec        = 1'b0;
        case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_nxt = coin_sum[CREDIT_W-1:0];
                        state_nxt  = COLLECT;
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end
                if (sel_valid) insufficient_nxt = 1'b1;
            end
            COLLECT: begin
                if (cancel) begin
                    coin_reject_nxt = coin_valid;
                    state_nxt       = CHANGE;
                end else if (sel_valid) begin
                    coin_reject_nxt = coin_valid;
                    if (stock_empty) begin
                        sold_out_nxt = 1'b1;
                    end else if (credit_q >= sel_price) begin
                        credit_nxt = credit_q - sel_price;
                        sel_nxt    = sel_id;
                        state_nxt  = VEND;
                    end else begin
                        insufficient_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
                    else coin_reject_nxt = 1'b1;
                end
            end
            VEND: begin
                coin_reject_nxt = coin_valid;
                if (motor_ack) begin
                    stock_dec = 1'b1;
                    state_nxt = (credit_q != '0) ? CHANGE : IDLE;
                end else if (tcnt == TW'(DISP_TIMEOUT - 1)) begin
                    // Motor never confirmed: give the price back so the customer is refunded in full.
                    fault_nxt  = 1'b1;
                    credit_nxt = credit_q + vend_price;
                    state_nxt  = CHANGE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            CHANGE: begin
                coin_reject_nxt = coin_valid;
                if (credit_q == '0) begin
                    state_nxt = IDLE;
                end else if (change_ack) begin
                    credit_nxt = credit_q - change_val;
                    if (credit_q == change_val) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credit_q     <= '0;
            sel_q        <= 2'd0;
            tcnt         <= '0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            sold_out     <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit_q     <= credit_nxt;
            sel_q        <= sel_nxt;
            tcnt         <= tcnt_nxt;
            coin_reject  <= coin_reject_nxt;
            insufficient <= insufficient_nxt;
            sold_out     <= sold_out_nxt;
            fault        <= fault_nxt;
        end
    end

`ifdef VEND_STOCK_EN
    logic [3:0] stock [4];

    assign stock_empty = (stock[sel_id] == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) stock[i] <= 4'(STOCK_INIT);
        end else if (stock_dec && (stock[sel_q] != 4'd0)) begin
            stock[sel_q] <= stock[sel_q] - 4'd1;
        end
    end
`else
    localparam int unused_stock_init = STOCK_INIT;
    logic unused_stock_dec;
    assign unused_stock_dec = stock_dec;
    assign stock_empty      = 1'b0;
`endif

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller; change coins are scored against an expected queue.
module tb_vend_txn_controller;

    localparam int CW = 8;
    localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_VEND = 2'd2, S_CHANGE = 2'd3;
    localparam logic [1:0] NICKEL = 2'b00, DIME = 2'b01, QUARTER = 2'b10, BAD = 2'b11;
`ifdef VEND_STOCK_EN
    localparam int TB_STOCK = 1;
`else
    localparam int TB_STOCK = 4;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          coin_valid, sel_valid, cancel, motor_ack, change_ack;
    logic [1:0]    coin_type, sel_id;
    logic          motor_req, change_valid, busy, coin_reject, insufficient, sold_out, fault;
    logic [1:0]    motor_id, change_type, state_dbg;
    logic [CW-1:0] credit;

    int checks = 0;
    int errors = 0;
    int exp_credit;
    logic [1:0] exp_q[$];

    vend_txn_controller #(.CREDIT_W(CW), .STOCK_INIT(TB_STOCK)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .motor_req(motor_req), .motor_id(motor_id), .motor_ack(motor_ack),
        .change_valid(change_valid), .change_type(change_type), .change_ack(change_ack),
        .credit(credit), .busy(busy), .coin_reject(coin_reject),
        .insufficient(insufficient), .sold_out(sold_out), .fault(fault),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int coin_value(input logic [1:0] t);
        case (t)
            NICKEL:  return 5;
            DIME:    return 10;
            QUARTER: return 25;
            default: return 0;
        endcase
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
    endtask

    task automatic insert_coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic ack_motor();
        motor_ack = 1'b1;
        step();
        motor_ack = 1'b0;
    endtask

    // scoreboard: pop each expected change coin and track credit
    task automatic drain_change();
        int guard;
        logic [1:0] t;
        while (exp_q.size() > 0) begin
            guard = 0;
            while (!change_valid && guard < 20) begin
                step();
                guard++;
            end
            if (!change_valid) begin
                check("change_wait", change_valid, 1);
                exp_q.delete();
            end else begin
                t = exp_q.pop_front();
                check("change_type", change_type, t);
                check("credit_before_ack", credit, exp_credit);
                change_ack = 1'b1;
                step();
                change_ack = 1'b0;
                exp_credit -= coin_value(t);
                check("credit_after_ack", credit, exp_credit);
            end
        end
        check("change_done_state", state_dbg, S_IDLE);
        check("change_done_valid", change_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0; sel_id = 2'b00;
        cancel = 1'b0; motor_ack = 1'b0; change_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_credit", credit, 0);
        check("rst_state", state_dbg, S_IDLE);
        check("rst_motor_req", motor_req, 0);
        check("rst_change_valid", change_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {coin_reject, insufficient, sold_out, fault}, 0);
        reset = 1'b0;
        step();

        // IDLE: bad coin, selection with no credit, cancel
        insert_coin(BAD);
        check("idle_bad_coin_reject", coin_reject, 1);
        check("idle_bad_coin_state", state_dbg, S_IDLE);
        step();
        check("reject_is_pulse", coin_reject, 0);
        select(2'd0);
        check("idle_sel_insufficient", insufficient, 1);
        press_cancel();
        check("idle_cancel_state", state_dbg, S_IDLE);

        // 1: quarter + dime, buy product 1 exactly
        insert_coin(QUARTER);
        check("t1_credit25", credit, 25);
        check("t1_collect", state_dbg, S_COLLECT);
        insert_coin(DIME);
        check("t1_credit35", credit, 35);
        select(2'd1);
        check("t1_vend_state", state_dbg, S_VEND);
        check("t1_motor_req", motor_req, 1);
        check("t1_motor_id", motor_id, 1);
        check("t1_credit0", credit, 0);
        check("t1_busy", busy, 1);
        insert_coin(NICKEL);
        check("t1_vend_coin_reject", coin_reject, 1);
        check("t1_vend_credit", credit, 0);
        ack_motor();
        check("t1_idle", state_dbg, S_IDLE);
        check("t1_motor_drop", motor_req, 0);
        check("t1_no_change", change_valid, 0);

        // 2: three quarters, buy product 2, one quarter back
        reset_dut();
        repeat (3) insert_coin(QUARTER);
        check("t2_credit75", credit, 75);
        select(2'd2);
        check("t2_credit25", credit, 25);
        check("t2_motor_id", motor_id, 2);
        ack_motor();
        check("t2_change_state", state_dbg, S_CHANGE);
        exp_credit = 25;
        exp_q.push_back(QUARTER);
        drain_change();

        // 3: cancel refunds quarter then dime
        reset_dut();
        insert_coin(QUARTER);
        insert_coin(DIME);
        press_cancel();
        check("t3_change_state", state_dbg, S_CHANGE);
        exp_credit = 35;
        exp_q.push_back(QUARTER);
        exp_q.push_back(DIME);
        drain_change();

        // 4: credit ceiling, then selection beats a same-cycle coin
        reset_dut();
        repeat (8) insert_coin(QUARTER);
        check("t4_credit200", credit, 200);
        insert_coin(NICKEL);
        check("t4_over_reject", coin_reject, 1);
        check("t4_credit_held", credit, 200);
        sel_valid = 1'b1; sel_id = 2'd0; coin_valid = 1'b1; coin_type = NICKEL;
        step();
        sel_valid = 1'b0; coin_valid = 1'b0;
        check("t4_vend_state", state_dbg, S_VEND);
        check("t4_credit175", credit, 175);
        check("t4_coin_reject", coin_reject, 1);
        check("t4_motor_id", motor_id, 0);
        ack_motor();
        exp_credit = 175;
        repeat (7) exp_q.push_back(QUARTER);
        drain_change();

        // 5: insufficient credit, then dispense timeout with full refund
        reset_dut();
        insert_coin(QUARTER);
        insert_coin(QUARTER);
        select(2'd3);
        check("t5_insufficient", insufficient, 1);
        check("t5_credit50", credit, 50);
        check("t5_collect", state_dbg, S_COLLECT);
        select(2'd2);
        check("t5_vend_credit0", credit, 0);
        repeat (15) step();
        check("t5_still_vend", state_dbg, S_VEND);
        check("t5_no_fault_yet", fault, 0);
        check("t5_motor_held", motor_req, 1);
        step();
        check("t5_fault", fault, 1);
        check("t5_change_state", state_dbg, S_CHANGE);
        check("t5_refund", credit, 50);
        check("t5_motor_drop", motor_req, 0);
        step();
        check("t5_fault_pulse", fault, 0);
        exp_credit = 50;
        exp_q.push_back(QUARTER);
        exp_q.push_back(QUARTER);
        drain_change();

        // reset mid-transaction clears credit without an edge
        insert_coin(DIME);
        check("mid_credit10", credit, 10);
        reset = 1'b1;
        #1;
        check("async_rst_credit", credit, 0);
        check("async_rst_state", state_dbg, S_IDLE);
        step();
        reset = 1'b0;
        step();
        check("no_sold_out", sold_out, 0);

`ifdef VEND_STOCK_EN
        // 6: single stock unit of product 0
        reset_dut();
        insert_coin(QUARTER);
        select(2'd0);
        check("t6_vend", state_dbg, S_VEND);
        ack_motor();
        check("t6_idle", state_dbg, S_IDLE);
        insert_coin(QUARTER);
        select(2'd0);
        check("t6_sold_out", sold_out, 1);
        check("t6_credit25", credit, 25);
        check("t6_collect", state_dbg, S_COLLECT);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
